// File: rtl/acc_pkg.sv
// Shared types for the accumulation scheduler: FSM state encoding and vector width.
package acc_pkg;

    localparam int VEC_W = 256;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BIAS     = 3'd1,
        ST_STREAM   = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_WAIT_OUT = 3'd4
    } acc_state_t;

endpackage

// File: rtl/acc_sched_delay.sv
// Delay line for the last-beat tag: dout follows din exactly SP_LAT cycles later.
module acc_sched_delay #(
    parameter int SP_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [SP_LAT-1:0] sr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_reg[0] <= 1'b0;
        else        sr_reg[0] <= din;
    end

    generate
        for (genvar gi = 1; gi < SP_LAT; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sr_reg[gi] <= 1'b0;
                else        sr_reg[gi] <= sr_reg[gi-1];
            end
        end
    endgenerate

    assign dout = sr_reg[SP_LAT-1];

endmodule

// File: rtl/accum_scheduler.sv
// Sequences bias injection, psum streaming and drain for one output tile.
// Optional performance counters are enabled with ACC_SCHED_PERF_EN.
module accum_scheduler
    import acc_pkg::*;
#(
    parameter int K_W    = 8,
    parameter int N_W    = 8,
    parameter int SP_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic [K_W-1:0]   cfg_k_steps,
    input  logic [N_W-1:0]   cfg_n_out,
    input  logic             cfg_bias_en,
    input  logic             bias_valid,
    output logic             bias_ready,
    input  logic [VEC_W-1:0] bias_data,
    input  logic             pe_valid,
    output logic             pe_ready,
    output logic             oc_valid,
    output logic             oc_bias_en,
    output logic [VEC_W-1:0] oc_bias_data,
    output logic             oc_accum_done,
    input  logic             oc_out_valid,
    output logic             busy,
    output logic             tile_done,
    output logic             cfg_err
`ifdef ACC_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_tile_cyc
`endif
);

    acc_state_t     state_reg;
    logic [K_W-1:0] k_reg;
    logic [K_W-1:0] beat_cnt_reg;
    logic [N_W-1:0] n_reg;
    logic [N_W-1:0] out_cnt_reg;
    logic [N_W-1:0] res_cnt_reg;
    logic           bias_en_reg;
    logic           tile_done_reg;
    logic           cfg_err_reg;

    logic [K_W-1:0] beat_cnt_next;
    logic [N_W-1:0] out_cnt_next;
    logic [N_W-1:0] res_cnt_next;
    logic           last_beat;
    logic           start_ok;
    logic           res_hit;

    assign busy         = (state_reg != ST_IDLE);
    assign pe_ready     = (state_reg == ST_STREAM);
    assign bias_ready   = (state_reg == ST_BIAS) && bias_valid;
    assign oc_bias_en   = bias_ready;
    assign oc_bias_data = oc_bias_en ? bias_data : '0;
    assign oc_valid     = pe_valid && pe_ready;
    assign tile_done    = tile_done_reg;
    assign cfg_err      = cfg_err_reg;

    assign beat_cnt_next = beat_cnt_reg + 1'b1;
    assign out_cnt_next  = out_cnt_reg + 1'b1;
    assign res_cnt_next  = res_cnt_reg + 1'b1;
    assign last_beat     = oc_valid && (beat_cnt_next == k_reg);
    assign start_ok      = cfg_start && (cfg_k_steps != '0) && (cfg_n_out != '0);
    // First term covers results that all arrived before WAIT_OUT was reached.
    assign res_hit       = (res_cnt_reg == n_reg) || (oc_out_valid && (res_cnt_next == n_reg));

    acc_sched_delay #(.SP_LAT(SP_LAT)) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (last_beat),
        .dout  (oc_accum_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            k_reg         <= '0;
            n_reg         <= '0;
            bias_en_reg   <= 1'b0;
            beat_cnt_reg  <= '0;
            out_cnt_reg   <= '0;
            res_cnt_reg   <= '0;
            tile_done_reg <= 1'b0;
            cfg_err_reg   <= 1'b0;
        end else begin
            tile_done_reg <= 1'b0;
            cfg_err_reg   <= 1'b0;
            if (busy && oc_out_valid && (res_cnt_reg != n_reg))
                res_cnt_reg <= res_cnt_next;
            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        k_reg       <= cfg_k_steps;
                        n_reg       <= cfg_n_out;
                        bias_en_reg <= cfg_bias_en;
                        state_reg   <= cfg_bias_en ? ST_BIAS : ST_STREAM;
                    end else if (cfg_start) begin
                        cfg_err_reg <= 1'b1;
                    end
                end
                ST_BIAS: begin
                    if (bias_valid) state_reg <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (last_beat) begin
                        beat_cnt_reg <= '0;
                        state_reg    <= ST_DRAIN;
                    end else if (oc_valid) begin
                        beat_cnt_reg <= beat_cnt_next;
                    end
                end
                ST_DRAIN: begin
                    if (oc_accum_done) begin
                        out_cnt_reg <= out_cnt_next;
                        if (out_cnt_next == n_reg) state_reg <= ST_WAIT_OUT;
                        else state_reg <= bias_en_reg ? ST_BIAS : ST_STREAM;
                    end
                end
                ST_WAIT_OUT: begin
                    if (res_hit) begin
                        tile_done_reg <= 1'b1;
                        beat_cnt_reg  <= '0;
                        out_cnt_reg   <= '0;
                        res_cnt_reg   <= '0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef ACC_SCHED_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] tile_cyc_reg;
    logic        stall_cyc;

    assign stall_cyc = ((state_reg == ST_STREAM) && !pe_valid) ||
                       ((state_reg == ST_BIAS) && !bias_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
            tile_cyc_reg  <= '0;
        end else if ((state_reg == ST_IDLE) && start_ok) begin
            stall_cnt_reg <= '0;
            tile_cyc_reg  <= '0;
        end else begin
            if (busy && (tile_cyc_reg != 32'hFFFF_FFFF))
                tile_cyc_reg <= tile_cyc_reg + 32'd1;
            if (stall_cyc && (stall_cnt_reg != 32'hFFFF_FFFF))
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_reg;
    assign perf_tile_cyc  = tile_cyc_reg;
`endif

endmodule

// File: tb/tb_accum_scheduler.sv
// Directed bench for accum_scheduler; perf counters are checked when ACC_SCHED_PERF_EN is defined.
module tb_accum_scheduler;
    import acc_pkg::*;

    localparam int K_W    = 8;
    localparam int N_W    = 8;
    localparam int SP_LAT = 2;

    logic             clk;
    logic             rst_n;
    logic             cfg_start;
    logic [K_W-1:0]   cfg_k_steps;
    logic [N_W-1:0]   cfg_n_out;
    logic             cfg_bias_en;
    logic             bias_valid;
    logic             bias_ready;
    logic [VEC_W-1:0] bias_data;
    logic             pe_valid;
    logic             pe_ready;
    logic             oc_valid;
    logic             oc_bias_en;
    logic [VEC_W-1:0] oc_bias_data;
    logic             oc_accum_done;
    logic             oc_out_valid;
    logic             busy;
    logic             tile_done;
    logic             cfg_err;
`ifdef ACC_SCHED_PERF_EN
    logic [31:0]      perf_stall_cnt;
    logic [31:0]      perf_tile_cyc;
`endif

    accum_scheduler #(.K_W(K_W), .N_W(N_W), .SP_LAT(SP_LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_start     (cfg_start),
        .cfg_k_steps   (cfg_k_steps),
        .cfg_n_out     (cfg_n_out),
        .cfg_bias_en   (cfg_bias_en),
        .bias_valid    (bias_valid),
        .bias_ready    (bias_ready),
        .bias_data     (bias_data),
        .pe_valid      (pe_valid),
        .pe_ready      (pe_ready),
        .oc_valid      (oc_valid),
        .oc_bias_en    (oc_bias_en),
        .oc_bias_data  (oc_bias_data),
        .oc_accum_done (oc_accum_done),
        .oc_out_valid  (oc_out_valid),
        .busy          (busy),
        .tile_done     (tile_done),
        .cfg_err       (cfg_err)
`ifdef ACC_SCHED_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_tile_cyc (perf_tile_cyc)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;

    // Event counters filled by the negedge monitor.
    int n_valid, n_acc, n_tile, n_bias, n_err;
    int last_acc_cyc, first_acc_cyc, first_bias_cyc, tile_at_cyc;
    logic       col_en;
    logic [2:0] col_pipe;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic clear_mon();
        n_valid = 0; n_acc = 0; n_tile = 0; n_bias = 0; n_err = 0;
        last_acc_cyc = -1000; first_acc_cyc = -1; first_bias_cyc = -1; tile_at_cyc = -1;
    endtask

    initial begin
        clear_mon();
        forever begin
            @(negedge clk);
            if (oc_valid) begin
                n_valid++;
                last_acc_cyc = cyc;
            end
            if (oc_accum_done) begin
                if (n_acc == 0) first_acc_cyc = cyc;
                n_acc++;
                check("accum_done_latency", cyc - last_acc_cyc, SP_LAT);
            end
            if (oc_bias_en) begin
                if (n_bias == 0) first_bias_cyc = cyc;
                n_bias++;
                check("bias_clear_of_psum", (cyc - last_acc_cyc) > SP_LAT, 1);
                check("bias_data_pass", oc_bias_data, bias_data);
            end
            if (tile_done) begin
                n_tile++;
                tile_at_cyc = cyc;
            end
            if (cfg_err) n_err++;
        end
    end

    // Collector stand-in: one result 3 cycles after each accum_done.
    initial begin
        oc_out_valid = 1'b0;
        col_pipe = '0;
        forever begin
            @(negedge clk);
            col_pipe = {col_pipe[1:0], oc_accum_done & col_en};
            @(posedge clk);
            #2;
            oc_out_valid = col_pipe[2];
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_tile(input int k, input int n, input logic b);
        cfg_k_steps = K_W'(k);
        cfg_n_out   = N_W'(n);
        cfg_bias_en = b;
        cfg_start   = 1'b1;
        start_cyc   = cyc;
        step();
        cfg_start   = 1'b0;
    endtask

    task automatic wait_tile(input int max_cyc);
        for (int i = 0; i < max_cyc && n_tile == 0; i++) step();
        check("tile_done_seen", n_tile != 0, 1);
    endtask

    function automatic logic [255:0] out_flags();
        return {248'd0, busy, pe_ready, bias_ready, oc_valid, oc_bias_en,
                oc_accum_done, tile_done, cfg_err};
    endfunction

    initial begin
        logic [4:0] pat;
        rst_n = 1'b0; cfg_start = 0; cfg_k_steps = 0; cfg_n_out = 0; cfg_bias_en = 0;
        bias_valid = 1'b1; pe_valid = 1'b1; bias_data = {8{32'hDEAD_BEEF}};
        col_en = 1'b1;
        #12;
        check("reset_flags", out_flags(), 0);
        check("reset_bias_data", oc_bias_data, 0);
        step();
        rst_n = 1'b1;
        #1;
        check("idle_flags", out_flags(), 0);
        step();

        // k=4, n=2, bias on, continuous psums
        clear_mon();
        start_tile(4, 2, 1'b1);
        #1;
        check("t1_busy", busy, 1);
        wait_tile(60);
        check("t1_oc_valid_cnt", n_valid, 8);
        check("t1_accum_done_cnt", n_acc, 2);
        check("t1_bias_cnt", n_bias, 2);
        check("t1_tile_done_cnt", n_tile, 1);
        check("t1_first_bias_at", first_bias_cyc - start_cyc, 1);
        check("t1_first_acc_at", first_acc_cyc - start_cyc, 7);
        check("t1_tile_done_at", tile_at_cyc - start_cyc, 18);
        #1;
        check("t1_idle_after", busy, 0);

        // k=3, n=1, bias off, gapped psums
        pe_valid = 1'b0; bias_valid = 1'b0;
        step();
        clear_mon();
        start_tile(3, 1, 1'b0);
        pat = 5'b10101;
        for (int i = 0; i < 5; i++) begin
            pe_valid = pat[i];
            step();
        end
        pe_valid = 1'b1;
        #1;
        check("t2_drain_pe_ready", pe_ready, 0);
        check("t2_drain_oc_valid", oc_valid, 0);
        step();
        pe_valid = 1'b0;
        wait_tile(40);
        check("t2_oc_valid_cnt", n_valid, 3);
        check("t2_bias_cnt", n_bias, 0);
        check("t2_accum_done_cnt", n_acc, 1);

        // bias stalls for 5 cycles
        step();
        clear_mon();
        pe_valid = 1'b1; bias_valid = 1'b0;
        start_tile(2, 1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_stall_pe_ready", pe_ready, 0);
            check("t3_stall_bias_ready", bias_ready, 0);
            step();
        end
        bias_valid = 1'b1;
        bias_data = {8{32'h1234_5678}};
        #1;
        check("t3_bias_handshake", {oc_bias_en, bias_ready}, 2'b11);
        step();
        bias_valid = 1'b0;
        wait_tile(40);
        pe_valid = 1'b0;
        check("t3_oc_valid_cnt", n_valid, 2);
        check("t3_bias_cnt", n_bias, 1);
`ifdef ACC_SCHED_PERF_EN
        check("t3_perf_stall", perf_stall_cnt, 5);
        check("t3_perf_tile_cyc", perf_tile_cyc, 13);
`endif

        // illegal starts and starts while busy
        step();
        clear_mon();
        start_tile(0, 1, 1'b0);
        #1;
        check("t4_err_k0", cfg_err, 1);
        check("t4_busy_k0", busy, 0);
        step();
        #1;
        check("t4_err_one_cycle", cfg_err, 0);
        start_tile(5, 0, 1'b0);
        #1;
        check("t4_err_n0", cfg_err, 1);
        step();
        clear_mon();
        start_tile(3, 1, 1'b0);
        cfg_k_steps = 0; cfg_start = 1'b1;
        step();
        cfg_k_steps = 1; cfg_start = 1'b1;
        #1;
        check("t4_busy_no_err", {busy, cfg_err}, 2'b10);
        step();
        cfg_start = 1'b0;
        #1;
        check("t4_busy_no_err2", {busy, cfg_err}, 2'b10);
        pe_valid = 1'b1;
        wait_tile(40);
        pe_valid = 1'b0;
        check("t4_k_kept", n_valid, 3);
        check("t4_err_cnt", n_err, 0);

        // reset in DRAIN
        step();
        clear_mon();
        col_en = 1'b0;
        pe_valid = 1'b1; bias_valid = 1'b1;
        start_tile(2, 1, 1'b0);
        step();
        step();
        #1;
        check("t5_in_drain", {busy, pe_ready}, 2'b10);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t5_reset_flags", out_flags(), 0);
        check("t5_reset_bias_data", oc_bias_data, 0);
        step();
        rst_n = 1'b1;
        pe_valid = 1'b0; bias_valid = 1'b0;
        repeat (10) step();
        check("t5_no_accum_done", n_acc, 0);
        check("t5_no_tile_done", n_tile, 0);
        col_en = 1'b1;

        // k=255 boundary
        clear_mon();
        pe_valid = 1'b1;
        start_tile(255, 1, 1'b0);
        wait_tile(400);
        pe_valid = 1'b0;
        check("t6_oc_valid_cnt", n_valid, 255);
        check("t6_accum_done_cnt", n_acc, 1);
        check("t6_acc_at", first_acc_cyc - start_cyc, 257);
        check("t6_tile_done_cnt", n_tile, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/accum_scheduler.md
ACCUM_SCHEDULER -- requirements
Module: accum_scheduler

Interface
REQ-001 SHALL have parameter K_W, default 8: width of the psum-beat count per output vector.
REQ-002 SHALL have parameter N_W, default 8: width of the output-vector count per tile.
REQ-003 SHALL have parameter SP_LAT, default 2: spatial-reduction latency in cycles, from psum beat accepted to reduced vector at the temporal accumulator; legal range >=1.
REQ-004 SHALL have ports (one clock; reset asynchronous, active-low):
  clk  in  1  clock
  rst_n  in  1  async active-low reset
  cfg_start  in  1  one-cycle tile start pulse
  cfg_k_steps  in  K_W  psum beats per output vector
  cfg_n_out  in  N_W  output vectors per tile
  cfg_bias_en  in  1  inject bias per output vector
  bias_valid  in  1  bias buffer has data
  bias_ready  out  1  bias consumed this cycle
  bias_data  in  256  bias vector
  pe_valid  in  1  PE array psum beat available
  pe_ready  out  1  scheduler accepts beat
  oc_valid  out  1  drives collector in_valid
  oc_bias_en  out  1  drives collector in_bias_en
  oc_bias_data  out  256  drives collector in_bias_data
  oc_accum_done  out  1  drives collector in_accum_done
  oc_out_valid  in  1  collector out_valid (monitored)
  busy  out  1  tile in progress
  tile_done  out  1  one-cycle pulse, tile complete
  cfg_err  out  1  one-cycle pulse, illegal start

Function
REQ-005 SHALL implement states IDLE, BIAS, STREAM, DRAIN, WAIT_OUT.
REQ-006 In IDLE, cfg_start with cfg_k_steps!=0 and cfg_n_out!=0 SHALL latch all cfg_* inputs and go to BIAS if cfg_bias_en, else STREAM.
REQ-007 cfg_start with a zero count SHALL pulse cfg_err for one cycle and remain in IDLE.
REQ-008 cfg_start outside IDLE SHALL be ignored, with no cfg_err.
REQ-009 In BIAS, bias_ready SHALL equal bias_valid; on handshake, oc_bias_en=1 and oc_bias_data=bias_data the same cycle, then the block SHALL go to STREAM.
REQ-010 oc_bias_en SHALL never be 1 in a cycle where a reduced vector reaches the temporal accumulator.
REQ-011 In STREAM, pe_ready SHALL be 1, and oc_valid SHALL equal pe_valid&pe_ready (combinational pass-through).
REQ-012 A beat counter SHALL count accepted beats; the beat that makes count==k_steps SHALL be tagged last, and the block SHALL then go to DRAIN with pe_ready low from the next cycle.
REQ-013 The last tag SHALL travel an SP_LAT-deep shift register; oc_accum_done SHALL pulse exactly SP_LAT cycles after the last beat was accepted.
REQ-014 DRAIN SHALL end in the oc_accum_done cycle; it SHALL then increment the output counter and go to BIAS/STREAM if outputs issued < n_out, else WAIT_OUT.
REQ-015 An oc_out_valid counter SHALL count collector results.
REQ-016 When that counter reaches n_out, the block SHALL pulse tile_done, clear the counters, and return to IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 pe_valid outside STREAM SHALL be back-pressured only, and SHALL never be dropped or counted.
REQ-019 Counters SHALL be exactly K_W/N_W bits wide; the maximum count 2^W-1 SHALL be legal with no wrap.

Reset
REQ-020 On rst_n low, the state SHALL become IDLE and all counters and the shift register SHALL clear.
REQ-021 On rst_n low, all outputs SHALL be 0 (oc_bias_data=0, busy=0).
REQ-022 A reset mid-tile SHALL abandon the tile with no tile_done.

Configuration
REQ-023 With ACC_SCHED_PERF_EN defined, the block SHALL add outputs perf_stall_cnt[31:0] and perf_tile_cyc[31:0].
  - perf_stall_cnt counts STREAM cycles with pe_valid=0, plus BIAS cycles with bias_valid=0.
  - perf_tile_cyc counts busy cycles.
  - Both clear on accepted cfg_start and saturate at 0xFFFFFFFF.
REQ-024 Without ACC_SCHED_PERF_EN, those ports and their logic SHALL be absent; behaviour is otherwise identical.

Structure
REQ-025 The state encoding enum and the 256-bit vector width constant SHALL live in the shared package acc_pkg.
REQ-026 The last-tag delay line SHALL be the sub-module acc_sched_delay (parameter SP_LAT, 1-bit shift register with async reset).

Verification
REQ-027 k=4, n=2, bias on, SP_LAT=2, pe_valid always 1:
  - Bias, 4 beats, accum_done 2 cycles after the 4th beat, repeated twice.
  - tile_done after the 2nd oc_out_valid.
REQ-028 k=3, n=1, bias off, pe_valid toggling 1,0,1,0,1: exactly 3 oc_valid pulses, and oc_bias_en never 1.
REQ-029 bias_valid low for 5 cycles in BIAS: pe_ready stays 0 for those cycles; with PERF_EN, perf_stall_cnt=5.
REQ-030 cfg_start with k=0: cfg_err pulses for 1 cycle, busy stays 0. cfg_start while busy: no effect.
REQ-031 rst_n asserted in DRAIN: all outputs 0 next edge; oc_accum_done and tile_done never pulse.
REQ-032 k=255, n=1: 255 beats accepted, the counter does not wrap, and accum_done pulses once.
